vedic_mul32_seq: RTL and testbench
==================================

# vedic_mul32_seq

Sequential unsigned 32x32 multiplier built around one shared combinational `Multiplier16x16` instance. The block takes operands over a valid/ready handshake and feeds the 16x16 core four half-word partial products in turn. It accumulates them into a 64-bit result and presents that result over a second valid/ready handshake. It sits between a requesting datapath and the existing Vedic 16x16 core, trading latency for area against a flat 32x32 array.

## Interface

Parameters:
- `OUT_REG`, default 0. When 1, a register is placed on the 16x16 product before accumulation, adding 1 cycle of latency and shortening the critical path.

Ports:
- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair is valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  32  unsigned multiplicand.
- `in_b`  in  32  unsigned multiplier.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_product`  out  64  unsigned product `in_a*in_b`.
- `busy`  out  1  high in every state except IDLE.

## Operation

- Unsigned only. Let aL/aH be `in_a[15:0]`/`in_a[31:16]`, and bL/bH likewise for `in_b`.
- Partial-product order is fixed:
  - P0 = aL*bL, shift 0
  - P1 = aL*bH, shift 16
  - P2 = aH*bL, shift 16
  - P3 = aH*bH, shift 32
- Core output is 33 bits. Bits [31:0] are used; bit 32 is ignored and is always 0 for 16x16 operands.
- Accumulator:
  - 64 bits, cleared on accept.
  - acc <= acc + (Pk << shift).
  - No overflow is possible, so no saturation or flag.
- Operands are captured into internal registers on accept. `in_a`/`in_b` may change afterwards without effect.
- FSM states: IDLE, MUL0, MUL1, MUL2, MUL3, DRAIN (only when OUT_REG=1), DONE.
- Transitions:
  - IDLE -> MUL0 on `in_valid && in_ready`.
  - MULk -> MULk+1.
  - MUL3 -> DONE when OUT_REG=0; MUL3 -> DRAIN when OUT_REG=1.
  - DRAIN -> DONE.
  - DONE -> IDLE on `out_valid && out_ready`.
- Core operand mux:
  - In state MULk, the core sees the half-words of Pk.
  - In IDLE, DRAIN and DONE, the core operands are driven to 0.
- Handshakes:
  - `in_ready` = (state==IDLE) && !rst. No new operands are accepted while a result is pending.
  - `out_valid` = (state==DONE).
  - `out_product` equals the accumulator and holds stable while `out_valid && !out_ready`.
  - `in_valid` while not ready is ignored; the requester must hold it.

## Timing

- Reset values: `in_ready`=0 while `rst` is high, and 1 in the first cycle after release. `out_valid`=0, `out_product`=0, `busy`=0. The accumulator and operand registers are 0.
- OUT_REG=0: accept at edge E0; accumulation at edges E1..E4; `out_valid` high from E4. Latency is 4 cycles.
- OUT_REG=1: issue at MUL0..MUL3; accumulation lags issue by 1 edge (E2..E5); `out_valid` high from E5. Latency is 5 cycles.
- Minimum initiation interval, with `out_ready` tied high:
  - OUT_REG=0: 6 cycles (4 MUL states + DONE + IDLE).
  - OUT_REG=1: 7 cycles.
- Reset mid-operation, in any state:
  - Next state is IDLE.
  - The accumulator and pipeline register are cleared.
  - The in-flight result is discarded.
  - `out_valid` does not assert for it.
- `out_ready` high outside DONE has no effect.
- `in_valid` and `out_ready` in the same cycle cannot collide, because `in_ready` is low in DONE.

## Structure

- Package `vedic_mul32_pkg` holds:
  - the state enum;
  - width constants (HALF_W=16, OP_W=32, PROD_W=64, CORE_P_W=33);
  - partial-product shift constants (0, 16, 16, 32).
- One sub-module: the existing `Multiplier16x16`, instantiated once. The FSM, operand mux, optional product register and accumulator stay in this module.

## Test plan

- **Reset:** hold `rst` 3 cycles with `in_valid`=1. Required: `in_ready`=0 and `out_valid`=0 throughout. After release: `in_ready`=1 and `out_product`=0.
- **Max operands:** A=B=0xFFFFFFFF. Required: `out_product`=0xFFFFFFFE00000001, with `out_valid` exactly 4 cycles after accept (5 with OUT_REG=1).
- **Cross terms:** A=0x00010000, B=0x00010000 gives 0x0000000100000000. A=0x0001FFFF, B=0x00020003 gives 0x000000040003FFFD.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`. Required:
  - the product stays stable;
  - `in_ready` stays 0;
  - a new `in_valid` is not accepted until the cycle after the `out_valid && out_ready` handshake.
- **Reset mid-op:** assert `rst` for 1 cycle in MUL2. Required: `out_valid` never asserts for that operation. A following A=3, B=5 yields 15.
- **Random:** 1000 random pairs with random `in_valid`/`out_ready` gaps, in both OUT_REG builds. Required: each `out_product` equals the reference product, delivered in order with no drops or duplicates.

Source files
------------

// File: rtl/vedic_mul32_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier
// that is built around a single 16x16 core.
package vedic_mul32_pkg;

    localparam int unsigned HALF_W   = 16;
    localparam int unsigned OP_W     = 32;
    localparam int unsigned PROD_W   = 64;
    localparam int unsigned CORE_P_W = 33;

    // Partial-product weights, in the order P0..P3: aL*bL, aL*bH, aH*bL, aH*bH.
    localparam int unsigned SH_P0 = 0;
    localparam int unsigned SH_P1 = 16;
    localparam int unsigned SH_P2 = 16;
    localparam int unsigned SH_P3 = 32;

    typedef enum logic [2:0] {
        IDLE,
        MUL0,
        MUL1,
        MUL2,
        MUL3,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/vedic_mul32_seq_mul16.sv
// Combinational 16x16 unsigned Vedic multiplier core.
// It is built from four 8x8 vertical/crosswise partial products.
module Multiplier16x16
    import vedic_mul32_pkg::*;
(
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [CORE_P_W-1:0] p
);

    logic [15:0] ll;
    logic [15:0] lh;
    logic [15:0] hl;
    logic [15:0] hh;
    logic [16:0] mid;

    assign ll  = 16'(a[7:0])  * 16'(b[7:0]);
    assign lh  = 16'(a[7:0])  * 16'(b[15:8]);
    assign hl  = 16'(a[15:8]) * 16'(b[7:0]);
    assign hh  = 16'(a[15:8]) * 16'(b[15:8]);
    assign mid = 17'(lh) + 17'(hl);

    assign p = 33'(ll) + (33'(mid) << 8) + (33'(hh) << 16);

endmodule

// File: rtl/vedic_mul32_seq.sv
// Sequential unsigned 32x32 multiplier. Four half-word products are issued
// through one shared 16x16 core and accumulated into a 64-bit result.
import vedic_mul32_pkg::*;

module vedic_mul32_seq #(
    parameter int unsigned OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic              busy
);

    state_t                state;
    state_t                state_nx;
    logic [OP_W-1:0]       a_q;
    logic [OP_W-1:0]       b_q;
    logic [HALF_W-1:0]     core_a;
    logic [HALF_W-1:0]     core_b;
    logic [CORE_P_W-1:0]   core_p;
    logic [CORE_P_W-1:0]   pp_q;
    logic [CORE_P_W-1:0]   pp;
    logic [PROD_W-1:0]     acc;
    logic                  add_en;
    logic [5:0]            add_sh;
    logic                  accept;

    assign in_ready    = (state == IDLE) && !rst;
    assign out_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign out_product = acc;
    assign accept      = in_valid && in_ready;

    Multiplier16x16 u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MUL0;
            MUL0:    state_nx = MUL1;
            MUL1:    state_nx = MUL2;
            MUL2:    state_nx = MUL3;
            MUL3:    state_nx = (OUT_REG != 0) ? DRAIN : DONE;
            DRAIN:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        core_a = '0;
        core_b = '0;
        case (state)
            MUL0: begin core_a = a_q[15:0];  core_b = b_q[15:0];  end
            MUL1: begin core_a = a_q[15:0];  core_b = b_q[31:16]; end
            MUL2: begin core_a = a_q[31:16]; core_b = b_q[15:0];  end
            MUL3: begin core_a = a_q[31:16]; core_b = b_q[31:16]; end
            default: ;
        endcase
    end

    // With the product register, each term is added one state after its issue,
    // so the weight follows the previous MUL state and DRAIN absorbs P3.
    always_comb begin
        add_en = 1'b0;
        add_sh = '0;
        if (OUT_REG != 0) begin
            pp = pp_q;
            case (state)
                MUL1:  begin add_en = 1'b1; add_sh = 6'(SH_P0); end
                MUL2:  begin add_en = 1'b1; add_sh = 6'(SH_P1); end
                MUL3:  begin add_en = 1'b1; add_sh = 6'(SH_P2); end
                DRAIN: begin add_en = 1'b1; add_sh = 6'(SH_P3); end
                default: ;
            endcase
        end else begin
            pp = core_p;
            case (state)
                MUL0: begin add_en = 1'b1; add_sh = 6'(SH_P0); end
                MUL1: begin add_en = 1'b1; add_sh = 6'(SH_P1); end
                MUL2: begin add_en = 1'b1; add_sh = 6'(SH_P2); end
                MUL3: begin add_en = 1'b1; add_sh = 6'(SH_P3); end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            pp_q  <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            pp_q  <= core_p;
            if (accept) begin
                a_q <= in_a;
                b_q <= in_b;
                acc <= '0;
            end else if (add_en) begin
                acc <= acc + (PROD_W'(pp) << add_sh);
            end
        end
    end

endmodule

// File: tb/tb_vedic_mul32_seq.sv
// Self-checking bench for vedic_mul32_seq, covering both OUT_REG builds
// against a plain 64-bit arithmetic reference.
module tb_vedic_mul32_seq;

    logic        clk;
    logic        rst;
    logic        in_valid    [2];
    logic        in_ready    [2];
    logic [31:0] in_a        [2];
    logic [31:0] in_b        [2];
    logic        out_valid   [2];
    logic        out_ready   [2];
    logic [63:0] out_product [2];
    logic        busy        [2];

    int checks;
    int errors;

    vedic_mul32_seq #(.OUT_REG(0)) dut0 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid[0]),
        .in_ready    (in_ready[0]),
        .in_a        (in_a[0]),
        .in_b        (in_b[0]),
        .out_valid   (out_valid[0]),
        .out_ready   (out_ready[0]),
        .out_product (out_product[0]),
        .busy        (busy[0])
    );

    vedic_mul32_seq #(.OUT_REG(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid[1]),
        .in_ready    (in_ready[1]),
        .in_a        (in_a[1]),
        .in_b        (in_b[1]),
        .out_valid   (out_valid[1]),
        .out_ready   (out_ready[1]),
        .out_product (out_product[1]),
        .busy        (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, wait for acceptance, then measure cycles to out_valid.
    task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        int n;
        in_valid[sel] = 1'b1;
        in_a[sel] = a;
        in_b[sel] = b;
        n = 0;
        while (!in_ready[sel] && n < 20) begin
            tick();
            n++;
        end
        check("accept_wait", 64'(in_ready[sel]), 64'd1);
        tick();
        in_valid[sel] = 1'b0;
        in_a[sel] = $urandom;
        in_b[sel] = $urandom;
        lat = 0;
        while (!out_valid[sel] && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_op(input int sel);
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
    endtask

    task automatic directed_op(input int sel, input string tag,
                               input logic [31:0] a, input logic [31:0] b);
        int lat;
        start_op(sel, a, b, lat);
        check({tag, "_lat"}, 64'(lat), 64'(4 + sel));
        check(tag, out_product[sel], ref_mul(a, b));
        finish_op(sel);
    endtask

    task automatic backpressure(input int sel);
        int lat;
        logic [31:0] a2;
        logic [31:0] b2;
        int bad_stable;
        int bad_ready;
        bad_stable = 0;
        bad_ready = 0;
        start_op(sel, 32'h1234_5678, 32'h9ABC_DEF0, lat);
        a2 = $urandom;
        b2 = $urandom;
        in_valid[sel] = 1'b1;
        in_a[sel] = a2;
        in_b[sel] = b2;
        for (int i = 0; i < 10; i++) begin
            if (out_product[sel] !== ref_mul(32'h1234_5678, 32'h9ABC_DEF0)) bad_stable++;
            if (in_ready[sel] !== 1'b0 || out_valid[sel] !== 1'b1) bad_ready++;
            tick();
        end
        check("bp_stable", 64'(bad_stable), 64'd0);
        check("bp_in_ready_low", 64'(bad_ready), 64'd0);
        check("bp_product", out_product[sel], ref_mul(32'h1234_5678, 32'h9ABC_DEF0));
        out_ready[sel] = 1'b1;
        tick();
        out_ready[sel] = 1'b0;
        check("bp_idle_after_hs", 64'(busy[sel]), 64'd0);
        check("bp_ready_after_hs", 64'(in_ready[sel]), 64'd1);
        tick();
        check("bp_second_accepted", 64'(busy[sel]), 64'd1);
        in_valid[sel] = 1'b0;
        lat = 0;
        while (!out_valid[sel] && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_second_product", out_product[sel], ref_mul(a2, b2));
        finish_op(sel);
    endtask

    task automatic reset_midop(input int sel);
        int seen;
        in_valid[sel] = 1'b1;
        in_a[sel] = 32'hDEAD_BEEF;
        in_b[sel] = 32'hCAFE_F00D;
        tick();
        in_valid[sel] = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        check("rst_mid_product_cleared", out_product[sel], 64'd0);
        for (int i = 0; i < 10; i++) begin
            if (out_valid[sel] !== 1'b0) seen++;
            tick();
        end
        check("rst_mid_no_out_valid", 64'(seen), 64'd0);
        directed_op(sel, "rst_mid_follow", 32'd3, 32'd5);
    endtask

    task automatic run_random(input int sel, input int total);
        logic [63:0] q[$];
        logic [63:0] exp;
        int sent;
        int recv;
        int cyc;
        bit fire_in;
        bit fire_out;
        sent = 0;
        recv = 0;
        cyc = 0;
        while (recv < total && cyc < 40000) begin
            if (!in_valid[sel] && sent < total && $urandom_range(0, 2) == 0) begin
                in_valid[sel] = 1'b1;
                case ($urandom_range(0, 7))
                    0:       begin in_a[sel] = 32'hFFFF_FFFF; in_b[sel] = $urandom; end
                    1:       begin in_a[sel] = $urandom;      in_b[sel] = 32'd0;    end
                    default: begin in_a[sel] = $urandom;      in_b[sel] = $urandom; end
                endcase
            end
            out_ready[sel] = ($urandom_range(0, 2) != 0);
            fire_in = in_valid[sel] && in_ready[sel];
            fire_out = out_valid[sel] && out_ready[sel];
            if (fire_out) begin
                exp = (q.size() > 0) ? q.pop_front() : 64'hXXXX_XXXX_XXXX_XXXX;
                check("rand_product", out_product[sel], exp);
                recv++;
            end
            if (fire_in) begin
                q.push_back(ref_mul(in_a[sel], in_b[sel]));
                sent++;
            end
            tick();
            cyc++;
            if (fire_in) begin
                in_valid[sel] = 1'b0;
                in_a[sel] = $urandom;
                in_b[sel] = $urandom;
            end
        end
        out_ready[sel] = 1'b0;
        check("rand_all_received", 64'(recv), 64'(total));
        check("rand_no_leftover", 64'(q.size()), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 1'b1;
            in_a[s] = 32'h0000_0007;
            in_b[s] = 32'h0000_0009;
            out_ready[s] = 1'b0;
        end

        for (int i = 0; i < 3; i++) begin
            tick();
            for (int s = 0; s < 2; s++) begin
                check("rst_in_ready", 64'(in_ready[s]), 64'd0);
                check("rst_out_valid", 64'(out_valid[s]), 64'd0);
            end
        end
        rst = 1'b0;
        in_valid[0] = 1'b0;
        in_valid[1] = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            check("post_rst_in_ready", 64'(in_ready[s]), 64'd1);
            check("post_rst_product", out_product[s], 64'd0);
            check("post_rst_busy", 64'(busy[s]), 64'd0);
        end
        tick();

        for (int s = 0; s < 2; s++) begin
            directed_op(s, "max_operands", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            check("max_literal", out_product[s], 64'hFFFF_FFFE_0000_0001);
            directed_op(s, "cross_16", 32'h0001_0000, 32'h0001_0000);
            check("cross_16_literal", out_product[s], 64'h0000_0001_0000_0000);
            directed_op(s, "cross_mixed", 32'h0001_FFFF, 32'h0002_0003);
            check("cross_mixed_literal", out_product[s], 64'h0000_0004_0003_FFFD);
            directed_op(s, "zero_operand", 32'h0000_0000, 32'hFFFF_FFFF);
            backpressure(s);
            reset_midop(s);
            run_random(s, 1000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
